// File: rtl/pattern_check_pkg.sv
// pattern_check_pkg: shared state encoding and direction constants for the triangle pattern checker.
`default_nettype none

package pattern_check_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/pattern_checker_if.sv
// pattern_checker_if: sample stream in, lock/error status out; err_count exists only with PATTERN_CHECKER_ERR_CNT_EN.
`default_nettype none

interface pattern_checker_if #(
  parameter int W = 3
);

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         locked;
  logic         err_pulse;
  logic         dir;
`ifdef PATTERN_CHECKER_ERR_CNT_EN
  logic [15:0]  err_count;

  modport master (output in_valid, in_data, input locked, err_pulse, dir, err_count);
  modport slave  (input in_valid, in_data, output locked, err_pulse, dir, err_count);
`else
  modport master (output in_valid, in_data, input locked, err_pulse, dir);
  modport slave  (input in_valid, in_data, output locked, err_pulse, dir);
`endif

endinterface

`default_nettype wire

// File: rtl/pattern_checker_tri_next.sv
// tri_next: next triangle-sequence value and direction from the last value and current direction.
`default_nettype none

module tri_next
  import pattern_check_pkg::*;
#(
  parameter int W = 3
) (
  input  wire logic [W-1:0] i_val,
  input  wire logic         i_dir,
  output logic      [W-1:0] o_next,
  output logic              o_dir
);

  localparam logic [W-1:0] c_MAX = '1;
  localparam logic [W-1:0] c_ONE = W'(1);

  always_comb begin
    o_next = i_val;
    o_dir  = i_dir;
    if (i_dir == DIR_UP) begin
      if (i_val != c_MAX) begin
        o_next = i_val + c_ONE;
      end else begin
        o_next = i_val - c_ONE;
        o_dir  = DIR_DOWN;
      end
    end else begin
      if (i_val != '0) begin
        o_next = i_val - c_ONE;
      end else begin
        o_next = i_val + c_ONE;
        o_dir  = DIR_UP;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_checker.sv
// pattern_checker: HUNT/SYNC/LOCKED tracker for a 0..MAX..0 triangle stream.
// Optional saturating error counter enabled by PATTERN_CHECKER_ERR_CNT_EN.
`default_nettype none

module pattern_checker
  import pattern_check_pkg::*;
#(
  parameter int W        = 3,
  parameter int SYNC_LEN = 4,
  parameter int LOSS_LEN = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  pattern_checker_if.slave  bus
);

  localparam int              c_RUN_W  = $clog2(SYNC_LEN + 1);
  localparam int              c_MISS_W = $clog2(LOSS_LEN + 1);
  localparam logic [W-1:0]    c_MAX    = '1;
  localparam logic [W-1:0]    c_ONE    = W'(1);
  localparam logic [c_RUN_W-1:0]  c_SYNC = c_RUN_W'(SYNC_LEN);
  localparam logic [c_MISS_W-1:0] c_LOSS = c_MISS_W'(LOSS_LEN);

  state_t                r_state;
  logic [W-1:0]          r_last;
  logic                  r_dir;
  logic [c_RUN_W-1:0]    r_run;
  logic [c_MISS_W-1:0]   r_miss;
  logic                  r_locked;
  logic                  r_err;

  logic [W-1:0]          w_exp;
  logic                  w_exp_dir;
  logic                  w_match;
  logic                  w_hunt_up;
  logic                  w_hunt_dn;
  logic [W-1:0]          w_upd_val;
  logic                  w_upd_dir;
  logic                  w_norm_dir;
  logic [c_RUN_W-1:0]    w_run_inc;
  logic [c_MISS_W-1:0]   w_miss_inc;

  tri_next #(.W(W)) u_tri_next (
    .i_val  (r_last),
    .i_dir  (r_dir),
    .o_next (w_exp),
    .o_dir  (w_exp_dir)
  );

  assign w_match    = (bus.in_data == w_exp);
  assign w_hunt_up  = (r_last != c_MAX) && (bus.in_data == r_last + c_ONE);
  assign w_hunt_dn  = (r_last != '0)    && (bus.in_data == r_last - c_ONE);
  assign w_run_inc  = r_run + c_RUN_W'(1);
  assign w_miss_inc = r_miss + c_MISS_W'(1);

  // LOCKED always follows the expected value so a single bad sample costs one error.
  always_comb begin
    w_upd_val = bus.in_data;
    w_upd_dir = r_dir;
    case (r_state)
      ST_HUNT: begin
        if (w_hunt_up)      w_upd_dir = DIR_UP;
        else if (w_hunt_dn) w_upd_dir = DIR_DOWN;
      end
      ST_SYNC: begin
        if (w_match) w_upd_dir = w_exp_dir;
      end
      ST_LOCKED: begin
        w_upd_val = w_exp;
        w_upd_dir = w_exp_dir;
      end
      default: ;
    endcase
  end

  // dir is stored as the direction of the next step, so it turns on the peak/floor sample itself.
  assign w_norm_dir = (w_upd_val == c_MAX) ? DIR_DOWN :
                      (w_upd_val == '0)    ? DIR_UP   : w_upd_dir;

`ifdef PATTERN_CHECKER_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err_count <= '0;
    end else if (bus.in_valid && (r_state == ST_LOCKED) && !w_match && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.err_count = r_err_count;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_HUNT;
      r_last   <= '0;
      r_dir    <= DIR_UP;
      r_run    <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bus.in_valid) begin
        r_last <= w_upd_val;
        r_dir  <= w_norm_dir;
        case (r_state)
          ST_HUNT: begin
            if (w_hunt_up || w_hunt_dn) begin
              r_state <= ST_SYNC;
              r_run   <= c_RUN_W'(1);
            end
          end
          ST_SYNC: begin
            if (!w_match) begin
              r_state <= ST_HUNT;
              r_run   <= '0;
            end else if (w_run_inc == c_SYNC) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_run    <= '0;
              r_miss   <= '0;
            end else begin
              r_run <= w_run_inc;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_miss <= '0;
            end else begin
              r_err <= 1'b1;
              if (w_miss_inc == c_LOSS) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_miss   <= '0;
              end else begin
                r_miss <= w_miss_inc;
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err;
  assign bus.dir       = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker: directed vector table on a W=3 checker plus a hand sequence on a W=1 checker.
`default_nettype none

module tb_pattern_checker;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pattern_checker_if #(.W(3)) if_a ();
  pattern_checker_if #(.W(1)) if_b ();

  pattern_checker #(.W(3), .SYNC_LEN(4), .LOSS_LEN(2)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a.slave)
  );

  pattern_checker #(.W(1), .SYNC_LEN(2), .LOSS_LEN(1)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b.slave)
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [2:0]  data;
    logic        e_lock;
    logic        e_err;
    logic        e_dir;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [2:0] d,
                     input logic l, input logic e, input logic dr, input logic [15:0] c);
    vec_t t;
    t.rst_n = r; t.vld = v; t.data = d;
    t.e_lock = l; t.e_err = e; t.e_dir = dr; t.e_cnt = c;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step_b(input logic r, input logic v, input logic d,
                        input logic l, input logic e, input logic dr, input int idx);
    @(negedge clk);
    rst_b = r; if_b.in_valid = v; if_b.in_data = d;
    @(posedge clk);
    #1;
    check("b_locked", idx, 16'(if_b.locked), 16'(l));
    check("b_err", idx, 16'(if_b.err_pulse), 16'(e));
    check("b_dir", idx, 16'(if_b.dir), 16'(dr));
  endtask

  initial begin
    if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.in_valid = 1'b0; if_b.in_data = '0;

    // rst_n, valid, data | locked, err, dir, count
    add(0,0,0, 0,0,1,0);
    add(1,1,0, 0,0,1,0);
    add(1,1,1, 0,0,1,0);
    add(1,1,2, 0,0,1,0);
    add(1,1,3, 0,0,1,0);
    add(1,1,4, 1,0,1,0);
    add(1,1,5, 1,0,1,0);
    add(1,1,6, 1,0,1,0);
    add(1,1,7, 1,0,0,0);
    add(1,1,6, 1,0,0,0);
    add(1,1,5, 1,0,0,0);
    add(1,1,4, 1,0,0,0);
    add(1,1,3, 1,0,0,0);
    add(1,1,2, 1,0,0,0);
    add(1,1,1, 1,0,0,0);
    add(1,1,0, 1,0,1,0);
    add(1,1,1, 1,0,1,0);
    add(1,1,2, 1,0,1,0);
    add(1,1,5, 1,1,1,1);
    add(1,1,4, 1,0,1,1);
    add(1,0,6, 1,0,1,1);
    add(1,0,0, 1,0,1,1);
    add(1,0,3, 1,0,1,1);
    add(1,1,5, 1,0,1,1);
    add(1,1,6, 1,0,1,1);
    add(1,1,7, 1,0,0,1);
    add(1,1,0, 1,1,0,2);
    add(1,1,0, 0,1,0,3);
    add(1,1,4, 0,0,0,3);
    add(1,1,3, 0,0,0,3);
    add(1,1,2, 0,0,0,3);
    add(1,1,1, 1,0,0,3);
    add(1,1,0, 1,0,1,3);
    add(1,1,7, 1,1,1,4);
    add(1,1,2, 1,0,1,4);
    add(1,1,0, 1,1,1,5);
    add(0,1,5, 0,0,1,0);
    add(1,1,1, 0,0,1,0);
    add(1,1,3, 0,0,1,0);
    add(1,1,4, 0,0,1,0);
    add(1,1,5, 0,0,1,0);
    add(1,1,6, 0,0,1,0);
    add(1,1,7, 1,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_a = vecs[i].rst_n;
      if_a.in_valid = vecs[i].vld;
      if_a.in_data  = vecs[i].data;
      @(posedge clk);
      #1;
      check("locked", i, 16'(if_a.locked), 16'(vecs[i].e_lock));
      check("err_pulse", i, 16'(if_a.err_pulse), 16'(vecs[i].e_err));
      check("dir", i, 16'(if_a.dir), 16'(vecs[i].e_dir));
`ifdef PATTERN_CHECKER_ERR_CNT_EN
      check("err_count", i, if_a.err_count, vecs[i].e_cnt);
`endif
    end

    @(negedge clk);
    if_a.in_valid = 1'b0;

    // W=1 stream 0,1,0,1 with SYNC_LEN=2, LOSS_LEN=1
    step_b(0,0,0, 0,0,1, 0);
    step_b(1,1,1, 0,0,0, 1);
    step_b(1,1,0, 1,0,1, 2);
    step_b(1,1,1, 1,0,0, 3);
    step_b(1,1,1, 0,1,1, 4);
`ifdef PATTERN_CHECKER_ERR_CNT_EN
    check("b_err_count", 4, if_b.err_count, 16'd1);
`endif
    step_b(1,0,1, 0,0,1, 5);
    step_b(1,1,1, 0,0,0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pattern_checker.md
PATTERN_CHECKER -- requirements
Module: pattern_checker

Interface
REQ-001 SHALL have parameter W, default 3, sample width; the triangle peak is MAX = 2^W-1.
REQ-002 SHALL have parameter SYNC_LEN, default 4, consecutive matches needed to declare lock.
REQ-003 SHALL have parameter LOSS_LEN, default 2, consecutive mismatches that drop lock.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, marks in_data as a sample this cycle.
REQ-007 SHALL have port in_data, input, W, received triangle-sequence sample.
REQ-008 SHALL have port locked, output, 1, high while in LOCKED.
REQ-009 SHALL have port err_pulse, output, 1, one-cycle pulse per mismatch while LOCKED.
REQ-010 SHALL have port dir, output, 1, current expected direction (1=up, 0=down).
REQ-011 SHALL have port err_count, output, 16, saturating error count (present only under the Configuration macro).

Function
REQ-012 SHALL treat the sequence as 0,1,..,MAX,MAX-1,..,0,1,..; no value repeats at either turnaround.
REQ-013 SHALL compute next-expected from last value v and dir: up with v<MAX gives v+1; up with v==MAX gives MAX-1 and dir=down; down with v>0 gives v-1; down with v==0 gives 1 and dir=up.
REQ-014 SHALL change no state on cycles with in_valid=0.
REQ-015 SHALL implement states HUNT, SYNC and LOCKED.
REQ-016 SHALL, in HUNT, compare each valid sample s with the stored last value L: s==L+1 (L<MAX) sets dir=up; s==L-1 (L>0) sets dir=down; either case stores last=s, run=1 and enters SYNC; any other s stores last=s and stays in HUNT.
REQ-017 SHALL, in SYNC, on a match advance last and increment run, enter LOCKED when run reaches SYNC_LEN, and on a mismatch store last=s and return to HUNT.
REQ-018 SHALL, in LOCKED, advance last to the expected value (not the received one) on every valid sample, so one corrupted sample yields exactly one error.
REQ-019 SHALL, in LOCKED, on a mismatch pulse err_pulse and increment miss_run, clear miss_run on a match, and enter HUNT when miss_run reaches LOSS_LEN.
REQ-020 SHALL register all outputs, with latency one cycle after the sample edge.
REQ-021 SHALL make locked and dir reflect the state and direction after that edge.
REQ-022 SHALL work correctly with W=1, where the sequence is 0,1,0,1.

Reset
REQ-023 SHALL, when rst=0 at a clock edge, set state=HUNT, last=0, dir=1, run=0, miss_run=0, locked=0, err_pulse=0 and err_count=0.
REQ-024 SHALL let reset take priority over in_valid and abort any SYNC or LOCKED progress.

Configuration
REQ-025 SHALL, when PATTERN_CHECKER_ERR_CNT_EN is defined, provide err_count: +1 per err_pulse, saturating at 16'hFFFF, cleared only by reset.
REQ-026 SHALL, when PATTERN_CHECKER_ERR_CNT_EN is undefined, omit the err_count port and its counter logic, leaving all other behaviour identical.

Structure
REQ-027 SHALL place the state encoding (HUNT/SYNC/LOCKED) and the direction constants in shared package pattern_check_pkg.
REQ-028 SHALL implement the REQ-013 next-value/direction logic as combinational sub-module tri_next, which the pattern generators can reuse.

Verification
REQ-029 SHALL cover: W=3, SYNC_LEN=4, valid samples 0,1,2,3,4 -> locked rises the cycle after the 5th sample; dir=1.
REQ-030 SHALL cover: locked, samples 5,6,7,6,5 -> no err_pulse; dir=0 after the 7 is consumed.
REQ-031 SHALL cover: locked with 3 expected, send 5 then 4 -> one err_pulse, err_count=1, locked stays 1.
REQ-032 SHALL cover: LOSS_LEN=2, locked, two consecutive bad samples -> err_pulse twice, locked=0, err_count=2, state HUNT.
REQ-033 SHALL cover: in_valid low for 3 cycles mid-stream, then resume with the correct next value -> no error, state and outputs held during the gap.
REQ-034 SHALL cover: rst=0 for one cycle while locked with err_count=5 -> next cycle locked=0, err_count=0, err_pulse=0.
